crop_frame_arbiter: RTL and testbench

Frame-granular two-source arbiter placed in front of the crop pipeline (crop filter plus output FIFO). It lets two independent pixel streams, A and B, share one crop instance. Exactly one source is granted for a whole input frame of IN_ROWS*IN_COLS pixels. Grants alternate round-robin at frame boundaries, and the block keeps per-source completed-frame counts.

---
 rtl/crop_frame_arbiter.sv | 139 +++++++++++++
 tb/tb_crop_frame_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/crop_frame_arbiter.sv
// Frame-granular round-robin arbiter that lets two pixel sources share one crop pipeline.
// A granted source owns the pipeline for a whole frame; per-source completed frames are counted.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | no frame owned; picks the next source unless hold is high
// ST_STREAM | grant_id source is routed to the crop pipeline until its last beat
module crop_frame_arbiter #(
  parameter int PIXEL_BIT_WIDTH = 12,
  parameter int IN_ROWS         = 40,
  parameter int IN_COLS         = 40,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIXEL_BIT_WIDTH-1:0] a_pixel,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [PIXEL_BIT_WIDTH-1:0] b_pixel,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic                       hold,
  output logic [PIXEL_BIT_WIDTH-1:0] crop_pixel_in,
  output logic                       crop_in_valid,
  input  logic                       crop_in_ready,
  output logic                       grant_id,
  output logic                       busy,
  output logic                       frame_done,
  output logic [FRAME_CNT_WIDTH-1:0] frames_a,
  output logic [FRAME_CNT_WIDTH-1:0] frames_b
);

  localparam int FRAME_PIXELS = IN_ROWS * IN_COLS;
  localparam int CNT_W        = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_PIXELS - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t                     state_q, state_d;
  logic                       grant_id_q, grant_id_d;
  logic                       last_grant_q, last_grant_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       frame_done_q, frame_done_d;
  logic [FRAME_CNT_WIDTH-1:0] frames_a_q, frames_a_d;
  logic [FRAME_CNT_WIDTH-1:0] frames_b_q, frames_b_d;
  logic                       beat;
  logic                       last_beat;

  // Zero-latency pass-through: only the owner sees ready, everything is quiet in IDLE.
  always_comb begin
    crop_in_valid = 1'b0;
    crop_pixel_in = '0;
    a_ready       = 1'b0;
    b_ready       = 1'b0;
    if (state_q == ST_STREAM) begin
      if (grant_id_q) begin
        crop_in_valid = b_valid;
        crop_pixel_in = b_pixel;
        b_ready       = crop_in_ready;
      end else begin
        crop_in_valid = a_valid;
        crop_pixel_in = a_pixel;
        a_ready       = crop_in_ready;
      end
    end
  end

  assign beat      = crop_in_valid && crop_in_ready;
  assign last_beat = beat && (cnt_q == LAST_CNT);

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    frames_a_d   = frames_a_q;
    frames_b_d   = frames_b_q;
    case (state_q)
      ST_IDLE: begin
        if (!hold && (a_valid || b_valid)) begin
          // On contention the source that did not own the previous frame wins.
          if (a_valid && b_valid) begin
            grant_id_d = ~last_grant_q;
          end else begin
            grant_id_d = b_valid;
          end
          last_grant_d = grant_id_d;
          state_d      = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (last_beat) begin
          cnt_d        = '0;
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
          if (grant_id_q) begin
            frames_b_d = frames_b_q + FRAME_CNT_WIDTH'(1);
          end else begin
            frames_a_d = frames_a_q + FRAME_CNT_WIDTH'(1);
          end
        end else if (beat) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
      frames_a_q   <= '0;
      frames_b_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
      frames_a_q   <= frames_a_d;
      frames_b_q   <= frames_b_d;
    end
  end

  assign grant_id   = grant_id_q;
  assign busy       = (state_q == ST_STREAM);
  assign frame_done = frame_done_q;
  assign frames_a   = frames_a_q;
  assign frames_b   = frames_b_q;

endmodule

// File: tb/tb_crop_frame_arbiter.sv
// Directed bench for crop_frame_arbiter with 4x4 frames; sources present a running index
// as pixel data (B offset by 0x800) so lost, duplicated or misrouted beats are visible.
module tb_crop_frame_arbiter;

  localparam int PW   = 12;
  localparam int FW   = 16;
  localparam int NPIX = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [PW-1:0] a_pixel, b_pixel, crop_pixel_in;
  logic          a_valid = 1'b0, b_valid = 1'b0, hold = 1'b0, crop_in_ready = 1'b0;
  logic          a_ready, b_ready, crop_in_valid, grant_id, busy, frame_done;
  logic [FW-1:0] frames_a, frames_b;

  int n_tests = 0;
  int n_fail  = 0;
  int a_idx   = 0;
  int b_idx   = 0;
  int w_cyc, s_cyc, errs;

  assign a_pixel = PW'(a_idx);
  assign b_pixel = 12'h800 | PW'(b_idx);

  always #5 clk = ~clk;

  crop_frame_arbiter #(
    .PIXEL_BIT_WIDTH(PW),
    .IN_ROWS        (4),
    .IN_COLS        (4),
    .FRAME_CNT_WIDTH(FW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .a_pixel      (a_pixel),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .b_pixel      (b_pixel),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .hold         (hold),
    .crop_pixel_in(crop_pixel_in),
    .crop_in_valid(crop_in_valid),
    .crop_in_ready(crop_in_ready),
    .grant_id     (grant_id),
    .busy         (busy),
    .frame_done   (frame_done),
    .frames_a     (frames_a),
    .frames_b     (frames_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) tick();
    reset = 1'b1;
  endtask

  // Waits for a grant, then streams nbeats beats checking routing every cycle.
  // raise_at: after that many beats, raise hold and make A request.
  task automatic run_frame(input logic gnt, input bit toggle, input int raise_at,
                           input int nbeats, output int wait_cyc, output int strm_cyc);
    int beats = 0;
    int ferr  = 0;
    int cyc   = 0;
    bit hs;
    wait_cyc = 0;
    while (!busy && wait_cyc < 20) begin
      tick();
      wait_cyc++;
    end
    chk("grant_busy", 32'(busy), 32'd1);
    chk("grant_id", 32'(grant_id), 32'(gnt));
    while (beats < nbeats && cyc < 100) begin
      crop_in_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      #1;
      if (busy !== 1'b1 || grant_id !== gnt || frame_done !== 1'b0) ferr++;
      if ((gnt ? b_ready : a_ready) !== crop_in_ready) ferr++;
      if ((gnt ? a_ready : b_ready) !== 1'b0) ferr++;
      if (crop_in_valid !== (gnt ? b_valid : a_valid)) ferr++;
      hs = crop_in_valid && crop_in_ready;
      if (hs && crop_pixel_in !== (gnt ? (12'h800 | PW'(b_idx)) : PW'(a_idx))) ferr++;
      tick();
      cyc++;
      if (hs) begin
        if (gnt) b_idx++;
        else a_idx++;
        beats++;
        if (beats == raise_at) begin
          hold    = 1'b1;
          a_valid = 1'b1;
        end
      end
    end
    strm_cyc = cyc;
    chk("frame_beats", 32'(beats), 32'(nbeats));
    chk("frame_stream_errs", 32'(ferr), 32'd0);
    if (nbeats == NPIX) begin
      chk("frame_done_pulse", 32'(frame_done), 32'd1);
      chk("frame_end_idle", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    // Reset held with both sources requesting.
    a_valid = 1'b1;
    b_valid = 1'b1;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd0);
    chk("rst_valid", 32'(crop_in_valid), 32'd0);
    chk("rst_pixel", 32'(crop_pixel_in), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_frames_a", 32'(frames_a), 32'd0);
    chk("rst_frames_b", 32'(frames_b), 32'd0);

    // A only, full-rate.
    b_valid       = 1'b0;
    crop_in_ready = 1'b1;
    reset         = 1'b1;
    run_frame(1'b0, 1'b0, -1, NPIX, w_cyc, s_cyc);
    a_valid = 1'b0;
    chk("a_only_cycles", 32'(s_cyc), 32'd16);
    chk("a_only_frames_a", 32'(frames_a), 32'd1);
    chk("a_only_frames_b", 32'(frames_b), 32'd0);
    tick();
    chk("a_only_done_once", 32'(frame_done), 32'd0);
    chk("a_only_idle", 32'(busy), 32'd0);

    // Both requesting continuously: A,B,A,B with one bubble between frames.
    a_valid = 1'b1;
    b_valid = 1'b1;
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      run_frame(1'((i % 2) != 0), 1'b0, -1, NPIX, w_cyc, s_cyc);
      if (i > 0) chk($sformatf("alt_bubble_%0d", i), 32'(w_cyc), 32'd1);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    chk("alt_frames_a", 32'(frames_a), 32'd2);
    chk("alt_frames_b", 32'(frames_b), 32'd2);

    // Backpressure: ready toggles, beats land on alternate cycles.
    do_reset(1);
    a_valid = 1'b1;
    run_frame(1'b0, 1'b1, -1, NPIX, w_cyc, s_cyc);
    a_valid       = 1'b0;
    crop_in_ready = 1'b1;
    chk("bp_cycles", 32'(s_cyc), 32'd31);
    chk("bp_frames_a", 32'(frames_a), 32'd1);

    // hold raised mid B frame with A then waiting.
    do_reset(1);
    b_valid = 1'b1;
    run_frame(1'b1, 1'b0, 8, NPIX, w_cyc, s_cyc);
    errs = 0;
    repeat (4) begin
      tick();
      if (busy !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0) errs++;
    end
    chk("hold_stays_idle", 32'(errs), 32'd0);
    hold = 1'b0;
    tick();
    chk("hold_release_busy", 32'(busy), 32'd1);
    chk("hold_release_grant", 32'(grant_id), 32'd0);
    run_frame(1'b0, 1'b0, -1, NPIX, w_cyc, s_cyc);
    a_valid = 1'b0;
    b_valid = 1'b0;
    chk("hold_frames_a", 32'(frames_a), 32'd1);
    chk("hold_frames_b", 32'(frames_b), 32'd1);

    // Reset after beat 7 of an A frame, then both valid.
    do_reset(1);
    a_valid = 1'b1;
    run_frame(1'b0, 1'b0, -1, 8, w_cyc, s_cyc);
    reset = 1'b0;
    tick();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_a_ready", 32'(a_ready), 32'd0);
    chk("midrst_frames_a", 32'(frames_a), 32'd0);
    a_idx   = 0;
    b_valid = 1'b1;
    reset   = 1'b1;
    run_frame(1'b0, 1'b0, -1, NPIX, w_cyc, s_cyc);
    chk("midrst_frames_a_after", 32'(frames_a), 32'd1);
    chk("midrst_frames_b_after", 32'(frames_b), 32'd0);
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
